counter_sequencer: RTL and testbench

Run-control sequencer for the 8-bit up/down counter in the counter_scan design.
- Turns single-cycle user command pulses (start, stop, load, clear, direction) into the counter's control strobes: clr, load, enable and mode.
- Generates the counting rate from an internal prescaler.
- Optionally halts at a programmed limit by monitoring the counter's q output.
- Sits between the button-conditioning logic and the counter instance.

---
 rtl/counter_sequencer.sv | 138 +++++++++++++
 tb/tb_counter_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run-control sequencer for the up/down counter: turns command pulses into
// registered clr/load/enable/mode strobes, paced by an internal prescaler.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_load,
  input  logic             cmd_clear,
  input  logic             cmd_dir,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_in,
  output logic             cnt_clr,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             cnt_mode,
  output logic [WIDTH-1:0] cnt_data,
  output logic             running,
  output logic             done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  state_t             r_state;
  logic [DIV_W-1:0]   r_presc;
  logic               r_cnt_clr;
  logic               r_cnt_load;
  logic               r_cnt_enable;
  logic               r_cnt_mode;
  logic [WIDTH-1:0]   r_cnt_data;
  logic               r_running;
  logic               r_done;

  state_t             w_state_next;
  logic [DIV_W-1:0]   w_presc_next;
  logic               w_clr_next;
  logic               w_load_next;
  logic               w_enable_next;
  logic               w_mode_next;
  logic [WIDTH-1:0]   w_data_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= S_INIT;
      r_presc      <= '0;
      r_cnt_clr    <= 1'b0;
      r_cnt_load   <= 1'b0;
      r_cnt_enable <= 1'b0;
      r_cnt_mode   <= 1'b0;
      r_cnt_data   <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_cnt_clr    <= w_clr_next;
      r_cnt_load   <= w_load_next;
      r_cnt_enable <= w_enable_next;
      r_cnt_mode   <= w_mode_next;
      r_cnt_data   <= w_data_next;
      r_running    <= (w_state_next == S_RUN);
      r_done       <= (w_state_next == S_DONE);
    end
  end

  // At most one strobe is raised per cycle thanks to the if/else priority chain.
  always_comb begin
    w_state_next  = r_state;
    w_presc_next  = r_presc;
    w_clr_next    = 1'b0;
    w_load_next   = 1'b0;
    w_enable_next = 1'b0;
    w_mode_next   = r_cnt_mode;
    w_data_next   = r_cnt_data;

    if (r_state == S_INIT) begin
      w_clr_next   = 1'b1;
      w_state_next = S_IDLE;
    end else begin
      if (cmd_dir) begin
        w_mode_next = ~r_cnt_mode;
      end

      if (cmd_clear) begin
        w_clr_next   = 1'b1;
        w_presc_next = '0;
        w_state_next = S_IDLE;
      end else if (cmd_load) begin
        w_load_next  = 1'b1;
        w_data_next  = load_val;
        w_presc_next = '0;
        w_state_next = (r_state == S_RUN) ? S_RUN : S_PAUSE;
      end else if (cmd_stop) begin
        // Stop outranks start; outside RUN it is simply dropped.
        if (r_state == S_RUN) begin
          w_state_next = S_PAUSE;
        end
      end else if (cmd_start && (r_state != S_RUN)) begin
        w_presc_next = '0;
        w_state_next = S_RUN;
      end else if (r_state == S_RUN) begin
        if (r_presc == PRESC_LAST) begin
          w_presc_next = '0;
          if (oneshot && (q_in == limit)) begin
            w_state_next = S_DONE;
          end else begin
            w_enable_next = 1'b1;
          end
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
    end
  end

  assign cnt_clr    = r_cnt_clr;
  assign cnt_load   = r_cnt_load;
  assign cnt_enable = r_cnt_enable;
  assign cnt_mode   = r_cnt_mode;
  assign cnt_data   = r_cnt_data;
  assign running    = r_running;
  assign done       = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DIV=4 and a behavioural counter
// closing the q feedback loop.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_start, cmd_stop, cmd_load, cmd_clear, cmd_dir;
  logic       oneshot;
  logic [7:0] limit, load_val, q_model;
  logic       cnt_clr, cnt_load, cnt_enable, cnt_mode, running, done;
  logic [7:0] cnt_data;
  logic [5:0] outs;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(8), .DIV(4), .DIV_W(3)) dut (
    .clk(clk), .clr(clr),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_load(cmd_load),
    .cmd_clear(cmd_clear), .cmd_dir(cmd_dir),
    .oneshot(oneshot), .limit(limit), .load_val(load_val), .q_in(q_model),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_mode(cnt_mode), .cnt_data(cnt_data),
    .running(running), .done(done)
  );

  assign outs = {cnt_clr, cnt_load, cnt_enable, cnt_mode, running, done};

  // Behavioural model of the downstream 8-bit up/down counter.
  always_ff @(posedge clk) begin
    if (clr || cnt_clr)   q_model <= 8'h00;
    else if (cnt_load)    q_model <= cnt_data;
    else if (cnt_enable)  q_model <= cnt_mode ? q_model - 8'd1 : q_model + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic count_enables(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cnt_enable) cnt++;
    end
  endtask

  task automatic first_enable(input int max_steps, output int idx);
    idx = 0;
    for (int i = 1; i <= max_steps; i++) begin
      step();
      if (cnt_enable && idx == 0) idx = i;
      if (idx != 0) break;
    end
  endtask

  initial begin
    int en_cnt;
    int idx;
    int k;

    clr = 1'b1;
    cmd_start = 0; cmd_stop = 0; cmd_load = 0; cmd_clear = 0; cmd_dir = 0;
    oneshot = 0; limit = 8'h00; load_val = 8'h00;

    // Reset and INIT pulse
    repeat (3) step();
    check("reset_outs", outs, 6'b000000);
    check("reset_data", cnt_data, 8'h00);
    clr = 1'b0;
    step();
    check("init_clr_pulse", outs, 6'b100000);
    step();
    check("idle_after_init", outs, 6'b000000);
    step();
    check("idle_hold", outs, 6'b000000);

    // Free counting
    cmd_start = 1; step(); cmd_start = 0;
    check("start_running", outs, 6'b000010);
    count_enables(40, en_cnt);
    check("ten_enables_in_40", en_cnt, 10);
    check("last_step_enable", cnt_enable, 1'b1);
    check("mode_up", cnt_mode, 1'b0);

    // Load during run restarts the prescaler
    load_val = 8'hF0; cmd_load = 1; step(); cmd_load = 0;
    check("load_in_run_outs", outs, 6'b010010);
    check("load_data", cnt_data, 8'hF0);
    first_enable(8, idx);
    check("enable_4_after_load", idx, 4);
    cmd_dir = 1; step(); cmd_dir = 0;
    check("dir_toggle_down", outs, 6'b000110);

    // Oneshot to limit 5
    cmd_stop = 1; step(); cmd_stop = 0;
    check("stop_to_pause", outs, 6'b000100);
    oneshot = 1; limit = 8'h05; load_val = 8'h00;
    cmd_load = 1; cmd_dir = 1; step(); cmd_load = 0; cmd_dir = 0;
    check("load_dir_from_pause", outs, 6'b010000);
    check("load_zero_data", cnt_data, 8'h00);
    step();
    cmd_start = 1; step(); cmd_start = 0;
    check("oneshot_start", outs, 6'b000010);
    en_cnt = 0; k = 0;
    while (!done && k < 40) begin
      step();
      k++;
      if (cnt_enable) en_cnt++;
    end
    check("oneshot_steps_to_done", k, 24);
    check("oneshot_enables", en_cnt, 5);
    check("oneshot_done_outs", outs, 6'b000001);
    check("oneshot_q_at_limit", q_model, 8'h05);
    count_enables(20, en_cnt);
    check("done_no_enables", en_cnt, 0);
    check("done_holds", outs, 6'b000001);
    cmd_start = 1; step(); cmd_start = 0;
    check("restart_from_done", outs, 6'b000010);

    // Priority: clear wins over load and start
    load_val = 8'hAA;
    cmd_clear = 1; cmd_load = 1; cmd_start = 1; step();
    cmd_clear = 0; cmd_load = 0; cmd_start = 0;
    check("priority_clear_only", outs, 6'b100000);
    check("priority_no_load", cnt_data, 8'h00);
    oneshot = 0;
    step();
    check("priority_idle", outs, 6'b000000);

    // Stop mid-period and hold
    cmd_start = 1; step(); cmd_start = 0;
    step(); step();
    cmd_stop = 1; step(); cmd_stop = 0;
    check("stop_mid_period", outs, 6'b000000);
    count_enables(10, en_cnt);
    check("pause_no_enables", en_cnt, 0);
    cmd_start = 1; step(); cmd_start = 0;
    first_enable(8, idx);
    check("resume_first_enable", idx, 4);

    // Mid-operation reset
    cmd_dir = 1; step(); cmd_dir = 0;
    check("dir_before_reset", cnt_mode, 1'b1);
    load_val = 8'h3C; cmd_load = 1; step(); cmd_load = 0;
    check("load_before_reset", outs, 6'b010110);
    check("data_before_reset", cnt_data, 8'h3C);
    clr = 1'b1; step();
    check("midrun_reset_outs", outs, 6'b000000);
    check("midrun_reset_data", cnt_data, 8'h00);
    clr = 1'b0; step();
    check("reinit_clr_pulse", outs, 6'b100000);
    step();
    check("reinit_idle", outs, 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
